// File: rtl/reg_alu_sequencer.sv
// Four-state sequencer: latch an instruction, read two registers, execute, write back.
// state | meaning: IDLE accept, READ capture operands, EXEC compute result, WRITE write back and pulse done.
module reg_alu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [4:0]  src1,
  input  logic [4:0]  src2,
  input  logic [4:0]  dst,
  output logic [4:0]  sr1,
  output logic [4:0]  sr2,
  input  logic [31:0] rdData1,
  input  logic [31:0] rdData2,
  output logic [4:0]  dr,
  output logic [31:0] wrData,
  output logic        write,
  output logic        done,
  output logic [15:0] ops_count
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic [2:0]  op_q;
  logic [31:0] a, b, result, alu_out;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    write     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~reset;
        if (in_valid && !reset) begin
          accept    = 1'b1;
          state_nxt = READ;
        end
      end
      READ: state_nxt = EXEC;
      EXEC: state_nxt = WRITE;
      WRITE: begin
        write     = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_out = '0;
    case (op_q)
      3'b000: alu_out = a + b;
      3'b001: alu_out = a - b;
      3'b010: alu_out = a & b;
      3'b011: alu_out = a | b;
      3'b100: alu_out = a ^ b;
      3'b101: alu_out = {31'b0, ($signed(a) < $signed(b))};
      3'b110: alu_out = a << b[4:0];
      3'b111: alu_out = a;
      default: alu_out = '0;
    endcase
  end

  // sr1/sr2 double as the latched sources so the bank sees them throughout READ.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= '0;
      sr1       <= '0;
      sr2       <= '0;
      dr        <= '0;
      a         <= '0;
      b         <= '0;
      result    <= '0;
      ops_count <= '0;
    end else begin
      if (accept) begin
        op_q <= op;
        sr1  <= src1;
        sr2  <= src2;
        dr   <= dst;
      end
      if (state == READ) begin
        a <= rdData1;
        b <= rdData2;
      end
      if (state == EXEC)  result    <= alu_out;
      if (state == WRITE) ops_count <= ops_count + 16'd1;
    end
  end

  assign wrData = result;

endmodule
